hu_sb: RTL and testbench
========================

Name: hu_sb

Overview:
- Parametrised successor of the pipeline hazard unit for the riscv core.
- Detects load-use hazards with a configurable load latency (multi-cycle bubble insertion via a countdown).
- Offers a no-forwarding mode that stalls on any RAW hazard and a configurable branch flush depth.
- Adds an x0 exclusion, a memory-busy watchdog and saturating performance counters. Sits beside the pipeline registers and drives their HAZARD_ctrl inputs.

Parameters:
- LOAD_LAT, 1: bubbles inserted per load-use hazard (1..15).
- BR_FLUSH_DEPTH, 1: taken branch flushes IF_DEC (1) or IF_DEC and DEC_EX (2).
- FWD_EN, 1: 1 = full forwarding present, stall only on load-use; 0 = stall on any RAW versus EX/MEM/WB.
- WB_BYPASS, 1: regfile write-through; if 1, WB producer is never a hazard in FWD_EN=0 mode.
- MEM_TIMEOUT, 255: consecutive busy cycles before the watchdog error is raised.
- CNT_W, 32: performance counter width.

Ports:
- clk_in  in  1  clock, rising edge.
- rst_n_in  in  1  reset, asynchronous, active-low.
- branch_cond_in  in  1  taken branch resolved in EX.
- instr_mem_busy_in  in  1  instruction memory not ready.
- data_mem_busy_in  in  1  data memory not ready.
- EXctrl_MEM_in  in  MEM_ctrl  memory control of the instruction in EX.
- EXdata_RD_in  in  5  EX destination register.
- EXdata_RDwe_in  in  1  EX writes RD.
- MEMdata_RD_in  in  5  MEM destination register.
- MEMdata_RDwe_in  in  1  MEM writes RD.
- WBdata_RD_in  in  5  WB destination register.
- WBdata_RDwe_in  in  1  WB writes RD.
- DECdata_RS1_in  in  5  DEC source register 1.
- DECdata_RS2_in  in  5  DEC source register 2.
- DECrs1_used_in  in  1  DEC instruction reads RS1.
- DECrs2_used_in  in  1  DEC instruction reads RS2.
- clear_cnt_in  in  1  synchronous clear of performance counters.
- PC_reg_out  out  HAZARD_ctrl  PC register control.
- IF_DEC_out  out  HAZARD_ctrl  IF/DEC register control.
- DEC_EX_out  out  HAZARD_ctrl  DEC/EX register control.
- EX_MEM_out  out  HAZARD_ctrl  EX/MEM register control.
- MEM_WB_out  out  HAZARD_ctrl  MEM/WB register control.
- load_use_out  out  1  bubble being inserted this cycle.
- mem_timeout_err_out  out  1  sticky watchdog error.
- stall_cnt_out  out  CNT_W  cycles with PC_reg_out = STALL.
- flush_cnt_out  out  CNT_W  taken-branch flush events.

Behaviour:
- Clock and reset: single clock clk_in; reset rst_n_in is asynchronous and active-low.
- Reset: lu_cnt, busy_cnt, mem_timeout_err_out and both performance counters clear to 0. Control outputs are combinational; with idle inputs all are NOP.
- Match definition: match(r) is true when r != 0, the producer's we = 1, and (r == RS1 and rs1_used) or (r == RS2 and rs2_used). Register x0 never causes a hazard.
- Load-use detection: lu_hit = (EXctrl_MEM_in.proc_req == REQUEST and EXctrl_MEM_in.we == READ and match(EX_RD)).
- Load-use response, per cycle, when lu_hit or lu_cnt != 0: PC_reg_out = STALL, IF_DEC_out = STALL, DEC_EX_out = FLUSH, load_use_out = 1.
- lu_cnt update:
  - On lu_hit with lu_cnt == 0, load lu_cnt with LOAD_LAT-1.
  - Otherwise, when lu_cnt != 0, decrement.
  - Total bubbles per hazard = LOAD_LAT exactly.
- RAW stall in FWD_EN = 0 mode: raw_hit = match(EX) or match(MEM) or (match(WB) and not WB_BYPASS). It produces the same output pattern as load-use but does not use lu_cnt; it re-evaluates every cycle.
- Taken branch: IF_DEC_out = FLUSH; also DEC_EX_out = FLUSH if BR_FLUSH_DEPTH = 2. PC_reg_out stays NOP. It overrides load-use and RAW stalls, since the DEC instruction is wrong-path, and clears lu_cnt to 0 on that edge.
- Memory busy (instr or data): all five outputs = STALL, overriding everything. lu_cnt is frozen, no flush is counted, and the branch is re-evaluated after the busy ends.
- Priority: busy > branch > load-use/RAW > default NOP.
- Watchdog: busy_cnt increments on each busy cycle, saturates at MEM_TIMEOUT, and clears when not busy. mem_timeout_err_out is set on reaching MEM_TIMEOUT and stays set until reset.
- Counters:
  - stall_cnt increments on each cycle with PC_reg_out = STALL (busy or hazard).
  - flush_cnt increments on each cycle with a branch flush applied (not during busy).
  - Both saturate at all-ones and are cleared by clear_cnt_in, which takes priority over increment.
- Reset mid-operation: lu_cnt and the watchdog are aborted immediately (asynchronous clear); no residual bubbles are inserted after reset release.

Decomposition:
- riscv_pkg holds the existing HAZARD_ctrl enum (NOP/STALL/FLUSH), MEM_ctrl, REQUEST and READ.
- riscv_pkg gains the HU_REG_W = 5 constant.
- Sub-module hu_perf_cnt (saturating counter with clear and enable, CNT_W parameter) is instantiated twice.

Test Plan:
1. LOAD_LAT = 1: load x5 in EX, DEC add reads x5 -> one cycle of PC/IF_DEC STALL, DEC_EX FLUSH, load_use_out = 1; NOP on the next cycle.
2. LOAD_LAT = 3, same stimulus -> exactly 3 consecutive bubble cycles; a busy pulse in the 2nd bubble extends it to 4 cycles with all outputs STALL during the pulse.
3. Load x0 in EX, DEC reads x0 -> all outputs NOP, lu_cnt stays 0; rs2_used = 0 with a matching RS2 -> no stall.
4. Load-use and branch_cond_in in the same cycle, BR_FLUSH_DEPTH = 2 -> IF_DEC and DEC_EX FLUSH, PC NOP, lu_cnt = 0, flush_cnt +1.
5. FWD_EN = 0, WB_BYPASS = 0: ALU writes x7 in MEM, DEC reads x7 -> stall for each cycle the match persists (2 cycles: MEM then WB).
6. MEM_TIMEOUT = 4, data_mem_busy_in held 4 cycles -> mem_timeout_err_out rises on the 4th busy edge and stays high after busy drops; stall_cnt = 4; clear_cnt_in -> stall_cnt = 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared pipeline control types and hazard helpers for the riscv core
package riscv_pkg;

   localparam int HU_REG_W = 5;

   typedef enum logic [1:0] {
      NOP   = 2'b00,
      STALL = 2'b01,
      FLUSH = 2'b10
   } HAZARD_ctrl;

   typedef enum logic {
      NO_REQUEST = 1'b0,
      REQUEST    = 1'b1
   } mem_req_e;

   typedef enum logic {
      READ  = 1'b0,
      WRITE = 1'b1
   } mem_we_e;

   typedef struct packed {
      mem_req_e proc_req;
      mem_we_e  we;
   } MEM_ctrl;

   // x0 is hardwired to zero, so it can never carry a dependency
   function automatic logic reg_match(
      input logic [HU_REG_W-1:0] rd,
      input logic                rd_we,
      input logic [HU_REG_W-1:0] rs1,
      input logic                rs1_used,
      input logic [HU_REG_W-1:0] rs2,
      input logic                rs2_used
   );
      return (rd != '0) && rd_we &&
             (((rd == rs1) && rs1_used) || ((rd == rs2) && rs2_used));
   endfunction

endpackage

// File: rtl/hu_perf_cnt.sv
// rtl/hu_perf_cnt.sv - saturating event counter with synchronous clear
module hu_perf_cnt #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != '1)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/hu_sb.sv
// rtl/hu_sb.sv - pipeline hazard unit: load-use countdown, RAW stalls, branch flush, memory watchdog
module hu_sb
   import riscv_pkg::*;
#(
   parameter int LOAD_LAT       = 1,
   parameter int BR_FLUSH_DEPTH = 1,
   parameter int FWD_EN         = 1,
   parameter int WB_BYPASS      = 1,
   parameter int MEM_TIMEOUT    = 255,
   parameter int CNT_W          = 32
) (
   input  logic                clk_in,
   input  logic                rst_n_in,
   input  logic                branch_cond_in,
   input  logic                instr_mem_busy_in,
   input  logic                data_mem_busy_in,
   input  MEM_ctrl             EXctrl_MEM_in,
   input  logic [HU_REG_W-1:0] EXdata_RD_in,
   input  logic                EXdata_RDwe_in,
   input  logic [HU_REG_W-1:0] MEMdata_RD_in,
   input  logic                MEMdata_RDwe_in,
   input  logic [HU_REG_W-1:0] WBdata_RD_in,
   input  logic                WBdata_RDwe_in,
   input  logic [HU_REG_W-1:0] DECdata_RS1_in,
   input  logic [HU_REG_W-1:0] DECdata_RS2_in,
   input  logic                DECrs1_used_in,
   input  logic                DECrs2_used_in,
   input  logic                clear_cnt_in,
   output HAZARD_ctrl          PC_reg_out,
   output HAZARD_ctrl          IF_DEC_out,
   output HAZARD_ctrl          DEC_EX_out,
   output HAZARD_ctrl          EX_MEM_out,
   output HAZARD_ctrl          MEM_WB_out,
   output logic                load_use_out,
   output logic                mem_timeout_err_out,
   output logic [CNT_W-1:0]    stall_cnt_out,
   output logic [CNT_W-1:0]    flush_cnt_out
);

   localparam int                WD_W      = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WD_W-1:0]   WD_LIMIT  = WD_W'(MEM_TIMEOUT);
   localparam logic [3:0]        LU_RELOAD = 4'(LOAD_LAT - 1);

   logic            busy;
   logic [3:0]      lu_cnt;
   logic [WD_W-1:0] busy_cnt;
   logic            ex_match;
   logic            mem_match;
   logic            wb_match;
   logic            lu_hit;
   logic            raw_hit;
   logic            hz_stall;
   logic            flush_evt;

   assign busy = instr_mem_busy_in | data_mem_busy_in;

   always_comb begin
      ex_match  = reg_match(EXdata_RD_in, EXdata_RDwe_in, DECdata_RS1_in, DECrs1_used_in,
                            DECdata_RS2_in, DECrs2_used_in);
      mem_match = reg_match(MEMdata_RD_in, MEMdata_RDwe_in, DECdata_RS1_in, DECrs1_used_in,
                            DECdata_RS2_in, DECrs2_used_in);
      wb_match  = reg_match(WBdata_RD_in, WBdata_RDwe_in, DECdata_RS1_in, DECrs1_used_in,
                            DECdata_RS2_in, DECrs2_used_in);
      lu_hit    = (EXctrl_MEM_in.proc_req == REQUEST) && (EXctrl_MEM_in.we == READ) && ex_match;
      // Without forwarding every in-flight producer blocks DEC until it retires
      raw_hit   = (FWD_EN == 0) &&
                  (ex_match || mem_match || (wb_match && (WB_BYPASS == 0)));
      hz_stall  = lu_hit || (lu_cnt != 4'd0) || raw_hit;
      flush_evt = branch_cond_in && !busy;
   end

   always_comb begin
      PC_reg_out   = NOP;
      IF_DEC_out   = NOP;
      DEC_EX_out   = NOP;
      EX_MEM_out   = NOP;
      MEM_WB_out   = NOP;
      load_use_out = 1'b0;
      if (busy) begin
         PC_reg_out = STALL;
         IF_DEC_out = STALL;
         DEC_EX_out = STALL;
         EX_MEM_out = STALL;
         MEM_WB_out = STALL;
      end else if (branch_cond_in) begin
         IF_DEC_out = FLUSH;
         if (BR_FLUSH_DEPTH == 2) begin
            DEC_EX_out = FLUSH;
         end
      end else if (hz_stall) begin
         PC_reg_out   = STALL;
         IF_DEC_out   = STALL;
         DEC_EX_out   = FLUSH;
         load_use_out = 1'b1;
      end
   end

   // Countdown of remaining bubbles; the hit cycle itself is the first bubble
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         lu_cnt <= 4'd0;
      end else if (busy) begin
         lu_cnt <= lu_cnt;
      end else if (branch_cond_in) begin
         lu_cnt <= 4'd0;
      end else if (lu_hit && (lu_cnt == 4'd0)) begin
         lu_cnt <= LU_RELOAD;
      end else if (lu_cnt != 4'd0) begin
         lu_cnt <= lu_cnt - 4'd1;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         busy_cnt            <= '0;
         mem_timeout_err_out <= 1'b0;
      end else if (busy) begin
         if (busy_cnt != WD_LIMIT) begin
            busy_cnt <= busy_cnt + WD_W'(1);
         end
         if (busy_cnt == WD_LIMIT - WD_W'(1)) begin
            mem_timeout_err_out <= 1'b1;
         end
      end else begin
         busy_cnt <= '0;
      end
   end

   hu_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk_in),
      .rst_n (rst_n_in),
      .clr   (clear_cnt_in),
      .en    (PC_reg_out == STALL),
      .cnt   (stall_cnt_out)
   );

   hu_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk_in),
      .rst_n (rst_n_in),
      .clr   (clear_cnt_in),
      .en    (flush_evt),
      .cnt   (flush_cnt_out)
   );

endmodule

// File: tb/tb_hu_sb.sv
// tb/tb_hu_sb.sv - directed vector bench for hu_sb in two parameter configurations
module tb_hu_sb;
   import riscv_pkg::*;

   localparam logic [9:0] V_NOP = 10'b00_00_00_00_00;
   localparam logic [9:0] V_STL = 10'b01_01_01_01_01;
   localparam logic [9:0] V_LU  = 10'b01_01_10_00_00;
   localparam logic [9:0] V_BR1 = 10'b00_10_00_00_00;
   localparam logic [9:0] V_BR2 = 10'b00_10_10_00_00;

   typedef struct {
      string      name;
      logic       br;
      logic       ib;
      logic       db;
      logic [1:0] op;
      logic [4:0] ex_rd;
      logic       ex_we;
      logic [4:0] mem_rd;
      logic       mem_we;
      logic [4:0] wb_rd;
      logic       wb_we;
      logic [4:0] rs1;
      logic       u1;
      logic [4:0] rs2;
      logic       u2;
      logic [9:0] exp_a;
      logic [9:0] exp_b;
      logic       lu_a;
      logic       lu_b;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       br, ib, db, clr;
   MEM_ctrl    ex_mem;
   logic [4:0] ex_rd, mem_rd, wb_rd, rs1, rs2;
   logic       ex_we, mem_we, wb_we, u1, u2;

   HAZARD_ctrl a_pc, a_ifd, a_dex, a_exm, a_mwb;
   HAZARD_ctrl b_pc, b_ifd, b_dex, b_exm, b_mwb;
   logic       a_lu, a_err, b_lu, b_err;
   logic [31:0] a_stall, a_flush;
   logic [2:0]  b_stall, b_flush;

   int tests = 0;
   int fails = 0;
   vec_t vecs[13];

   always #5 clk = ~clk;

   hu_sb u_a (
      .clk_in(clk), .rst_n_in(rst_n), .branch_cond_in(br), .instr_mem_busy_in(ib),
      .data_mem_busy_in(db), .EXctrl_MEM_in(ex_mem), .EXdata_RD_in(ex_rd),
      .EXdata_RDwe_in(ex_we), .MEMdata_RD_in(mem_rd), .MEMdata_RDwe_in(mem_we),
      .WBdata_RD_in(wb_rd), .WBdata_RDwe_in(wb_we), .DECdata_RS1_in(rs1),
      .DECdata_RS2_in(rs2), .DECrs1_used_in(u1), .DECrs2_used_in(u2),
      .clear_cnt_in(clr), .PC_reg_out(a_pc), .IF_DEC_out(a_ifd), .DEC_EX_out(a_dex),
      .EX_MEM_out(a_exm), .MEM_WB_out(a_mwb), .load_use_out(a_lu),
      .mem_timeout_err_out(a_err), .stall_cnt_out(a_stall), .flush_cnt_out(a_flush)
   );

   hu_sb #(
      .LOAD_LAT(3), .BR_FLUSH_DEPTH(2), .FWD_EN(0), .WB_BYPASS(0),
      .MEM_TIMEOUT(4), .CNT_W(3)
   ) u_b (
      .clk_in(clk), .rst_n_in(rst_n), .branch_cond_in(br), .instr_mem_busy_in(ib),
      .data_mem_busy_in(db), .EXctrl_MEM_in(ex_mem), .EXdata_RD_in(ex_rd),
      .EXdata_RDwe_in(ex_we), .MEMdata_RD_in(mem_rd), .MEMdata_RDwe_in(mem_we),
      .WBdata_RD_in(wb_rd), .WBdata_RDwe_in(wb_we), .DECdata_RS1_in(rs1),
      .DECdata_RS2_in(rs2), .DECrs1_used_in(u1), .DECrs2_used_in(u2),
      .clear_cnt_in(clr), .PC_reg_out(b_pc), .IF_DEC_out(b_ifd), .DEC_EX_out(b_dex),
      .EX_MEM_out(b_exm), .MEM_WB_out(b_mwb), .load_use_out(b_lu),
      .mem_timeout_err_out(b_err), .stall_cnt_out(b_stall), .flush_cnt_out(b_flush)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic ex_idle();
      ex_mem = '{proc_req: NO_REQUEST, we: READ};
      ex_rd  = 5'd0;
      ex_we  = 1'b0;
   endtask

   task automatic all_idle();
      br = 1'b0; ib = 1'b0; db = 1'b0; clr = 1'b0;
      ex_idle();
      mem_rd = 5'd0; mem_we = 1'b0; wb_rd = 5'd0; wb_we = 1'b0;
      rs1 = 5'd0; rs2 = 5'd0; u1 = 1'b0; u2 = 1'b0;
   endtask

   task automatic load_x5();
      ex_mem = '{proc_req: REQUEST, we: READ};
      ex_rd  = 5'd5;
      ex_we  = 1'b1;
      rs1    = 5'd5;
      u1     = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      all_idle();
      #2;
      rst_n = 1'b1;
      step();
   endtask

   task automatic apply_vec(input vec_t v);
      br = v.br; ib = v.ib; db = v.db;
      ex_mem.proc_req = (v.op != 2'd0) ? REQUEST : NO_REQUEST;
      ex_mem.we       = (v.op == 2'd2) ? WRITE : READ;
      ex_rd = v.ex_rd; ex_we = v.ex_we;
      mem_rd = v.mem_rd; mem_we = v.mem_we;
      wb_rd = v.wb_rd; wb_we = v.wb_we;
      rs1 = v.rs1; u1 = v.u1; rs2 = v.rs2; u2 = v.u2;
   endtask

   initial begin
      logic [1:0] s2_pc[5];
      logic [1:0] s2_dex[5];

      //          name         br ib db op rd we mrd mwe wrd wwe rs1 u1 rs2 u2 exp_a  exp_b  la lb
      vecs[0]  = '{"idle",      0, 0, 0, 0, 0, 0, 0,  0,  0,  0,  0,  0, 0,  0, V_NOP, V_NOP, 0, 0};
      vecs[1]  = '{"lu_rs1",    0, 0, 0, 1, 5, 1, 0,  0,  0,  0,  5,  1, 0,  0, V_LU,  V_LU,  1, 1};
      vecs[2]  = '{"lu_x0",     0, 0, 0, 1, 0, 1, 0,  0,  0,  0,  0,  1, 0,  1, V_NOP, V_NOP, 0, 0};
      vecs[3]  = '{"rs2_unused",0, 0, 0, 1, 5, 1, 0,  0,  0,  0,  3,  1, 5,  0, V_NOP, V_NOP, 0, 0};
      vecs[4]  = '{"lu_branch", 1, 0, 0, 1, 5, 1, 0,  0,  0,  0,  5,  1, 0,  0, V_BR1, V_BR2, 0, 0};
      vecs[5]  = '{"raw_mem",   0, 0, 0, 0, 0, 0, 7,  1,  0,  0,  7,  1, 0,  0, V_NOP, V_LU,  0, 1};
      vecs[6]  = '{"raw_wb",    0, 0, 0, 0, 0, 0, 0,  0,  7,  1,  0,  0, 7,  1, V_NOP, V_LU,  0, 1};
      vecs[7]  = '{"raw_ex",    0, 0, 0, 0, 9, 1, 0,  0,  0,  0,  9,  1, 0,  0, V_NOP, V_LU,  0, 1};
      vecs[8]  = '{"dbusy_lu",  0, 0, 1, 1, 5, 1, 0,  0,  0,  0,  5,  1, 0,  0, V_STL, V_STL, 0, 0};
      vecs[9]  = '{"ibusy_br",  1, 1, 0, 0, 0, 0, 0,  0,  0,  0,  0,  0, 0,  0, V_STL, V_STL, 0, 0};
      vecs[10] = '{"store_ex",  0, 0, 0, 2, 5, 1, 0,  0,  0,  0,  5,  1, 0,  0, V_NOP, V_LU,  0, 1};
      vecs[11] = '{"mem_nowe",  0, 0, 0, 0, 0, 0, 7,  0,  0,  0,  7,  1, 0,  0, V_NOP, V_NOP, 0, 0};
      vecs[12] = '{"x0_mem",    0, 0, 0, 0, 0, 0, 0,  1,  0,  0,  0,  1, 0,  0, V_NOP, V_NOP, 0, 0};

      rst_n = 1'b0;
      all_idle();
      #12;
      chk("rst_a_ctrl", {a_pc, a_ifd, a_dex, a_exm, a_mwb}, V_NOP);
      chk("rst_b_ctrl", {b_pc, b_ifd, b_dex, b_exm, b_mwb}, V_NOP);
      chk("rst_b_err", b_err, 0);
      chk("rst_a_stall", a_stall, 0);
      chk("rst_b_flush", b_flush, 0);

      foreach (vecs[i]) begin
         do_reset();
         apply_vec(vecs[i]);
         #1;
         chk({vecs[i].name, "_a_ctrl"}, {a_pc, a_ifd, a_dex, a_exm, a_mwb}, vecs[i].exp_a);
         chk({vecs[i].name, "_b_ctrl"}, {b_pc, b_ifd, b_dex, b_exm, b_mwb}, vecs[i].exp_b);
         chk({vecs[i].name, "_a_lu"}, a_lu, vecs[i].lu_a);
         chk({vecs[i].name, "_b_lu"}, b_lu, vecs[i].lu_b);
      end

      // one-shot load: 1 bubble in u_a, 3 bubbles in u_b
      do_reset();
      load_x5();
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("lat_a_lu", a_lu, k == 0);
         chk("lat_b_lu", b_lu, k < 3);
         step();
         ex_idle();
      end

      // busy pulse during the second bubble stretches the window to four cycles
      s2_pc  = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
      s2_dex = '{2'd2, 2'd1, 2'd2, 2'd2, 2'd0};
      do_reset();
      load_x5();
      for (int k = 0; k < 5; k++) begin
         db = (k == 1);
         #1;
         chk("busy_b_pc", b_pc, s2_pc[k]);
         chk("busy_b_dex", b_dex, s2_dex[k]);
         step();
         ex_idle();
      end
      db = 1'b0;

      // branch together with load-use clears the countdown and counts one flush
      do_reset();
      load_x5();
      br = 1'b1;
      step();
      br = 1'b0;
      ex_idle();
      #1;
      chk("br_b_lu_cleared", b_lu, 0);
      chk("br_a_flush", a_flush, 1);
      chk("br_b_flush", b_flush, 1);
      chk("br_b_stall", b_stall, 0);

      // RAW on x7 persists through MEM and WB in the no-forwarding unit
      do_reset();
      mem_rd = 5'd7; mem_we = 1'b1; rs1 = 5'd7; u1 = 1'b1;
      #1;
      chk("raw_cyc0_b_lu", b_lu, 1);
      step();
      mem_rd = 5'd0; mem_we = 1'b0; wb_rd = 5'd7; wb_we = 1'b1;
      #1;
      chk("raw_cyc1_b_lu", b_lu, 1);
      chk("raw_cyc1_a_lu", a_lu, 0);
      step();
      wb_rd = 5'd0; wb_we = 1'b0;
      #1;
      chk("raw_cyc2_b_lu", b_lu, 0);
      chk("raw_b_stall", b_stall, 2);
      chk("raw_a_stall", a_stall, 0);

      // watchdog: error on the 4th busy edge, sticky afterwards
      do_reset();
      db = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         step();
         chk("wd_b_err", b_err, k == 4);
      end
      chk("wd_a_err", a_err, 0);
      db = 1'b0;
      step();
      chk("wd_b_err_sticky", b_err, 1);
      chk("wd_b_stall", b_stall, 4);
      chk("wd_a_stall", a_stall, 4);
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("clr_a_stall", a_stall, 0);
      chk("clr_b_stall", b_stall, 0);

      // 3-bit counter saturates at 7
      db = 1'b1;
      for (int k = 0; k < 10; k++) step();
      db = 1'b0;
      chk("sat_b_stall", b_stall, 7);
      chk("sat_a_stall", a_stall, 10);

      // asynchronous reset aborts a pending countdown
      load_x5();
      step();
      ex_idle();
      #1;
      chk("arst_pre_b_lu", b_lu, 1);
      rst_n = 1'b0;
      #1;
      chk("arst_b_err", b_err, 0);
      chk("arst_b_stall", b_stall, 0);
      rst_n = 1'b1;
      step();
      chk("arst_post_b_lu", b_lu, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
